// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-requester round-robin AHB-Lite front end for one AHBGPIO, with wait-state timeout.
// Define GPIO_ARB_LOCK_EN to add REQ_LOCK, which keeps priority on a requester across consecutive commands.
module gpio_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h5300_0000,
    parameter int          DATA_W      = 16,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [1:0]        REQ,
    input  logic [1:0]        REQ_WR,
    input  logic [1:0]        REQ_DIR,
    input  logic [DATA_W-1:0] REQ_WDATA0,
    input  logic [DATA_W-1:0] REQ_WDATA1,
`ifdef GPIO_ARB_LOCK_EN
    input  logic [1:0]        REQ_LOCK,
`endif
    output logic [1:0]        ACK,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        PENDING,
    output logic              HSEL,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [31:0]       HWDATA,
    output logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HREADYOUT
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t            state_q, state_d;
    logic [1:0]        pend_q, pend_d, wr_q, wr_d, dir_q, dir_d, lock_q, lock_d;
    logic [DATA_W-1:0] wd0_q, wd0_d, wd1_q, wd1_d, rdata_q, rdata_d;
    logic              ptr_q, ptr_d, grant_q, grant_d, err_q, err_d, hold_q, hold_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        take, done, lock_in;
    logic              timeout, unused_hrdata;

`ifdef GPIO_ARB_LOCK_EN
    assign lock_in = REQ_LOCK;
`else
    assign lock_in = 2'b00;
`endif
    assign unused_hrdata = ^HRDATA[31:DATA_W];

    // a slot is free again in its own RESP cycle, so a back-to-back REQ is not lost
    assign done    = (state_q == RESP) ? (2'b01 << grant_q) : 2'b00;
    assign take    = REQ & (~pend_q | done);
    assign timeout = !HREADYOUT && cnt_q == 8'(TIMEOUT_CYC - 1);

    always_comb begin
        pend_d  = take | (pend_q & ~done);
        wr_d    = (take & REQ_WR) | (~take & wr_q);
        dir_d   = (take & REQ_DIR) | (~take & dir_q);
        lock_d  = (take & lock_in) | (~take & lock_q);
        wd0_d   = take[0] ? REQ_WDATA0 : wd0_q;
        wd1_d   = take[1] ? REQ_WDATA1 : wd1_q;
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|pend_q) begin
                grant_d = (hold_q && pend_q[grant_q]) ? grant_q : (&pend_q) ? ~ptr_q : pend_q[1];
                state_d = ADDR;
                cnt_d   = '0;
                err_d   = 1'b0;
                hold_d  = 1'b0;
            end
            ADDR: begin
                state_d = HREADYOUT ? DATA : timeout ? RESP : ADDR;
                cnt_d   = HREADYOUT ? '0 : cnt_q + 8'd1;
                err_d   = timeout;
            end
            DATA: begin
                state_d = HREADYOUT ? RESP : timeout ? RESP : DATA;
                cnt_d   = cnt_q + 8'd1;
                err_d   = timeout;
                rdata_d = (HREADYOUT && !wr_q[grant_q]) ? HRDATA[DATA_W-1:0] : rdata_q;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = lock_q[grant_q] ? ptr_q : grant_q;
                hold_d  = lock_q[grant_q];
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            pend_q  <= '0;
            wr_q    <= '0;
            dir_q   <= '0;
            lock_q  <= '0;
            wd0_q   <= '0;
            wd1_q   <= '0;
            rdata_q <= '0;
            ptr_q   <= 1'b1;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            dir_q   <= dir_d;
            lock_q  <= lock_d;
            wd0_q   <= wd0_d;
            wd1_q   <= wd1_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ACK     = done;
    assign ERR     = (state_q == RESP) && err_q;
    assign RDATA   = rdata_q;
    assign PENDING = pend_q;
    assign HSEL    = state_q == ADDR;
    assign HTRANS  = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign HWRITE  = (state_q == ADDR) && wr_q[grant_q];
    assign HADDR   = (state_q == ADDR) ? BASE_ADDR + {29'd0, dir_q[grant_q], 2'b00} : 32'd0;
    assign HWDATA  = (state_q == DATA) ? {{(32-DATA_W){1'b0}}, grant_q ? wd1_q : wd0_q} : 32'd0;
    assign HREADY  = HREADYOUT;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: transaction-level model plus scoreboard; the bench also plays the GPIO slave.
module tb_gpio_bus_arbiter;
    localparam logic [31:0] BASE = 32'h5300_0000;
    localparam int TO = 16;

    logic HCLK = 0, HRESETn = 0, HREADYOUT = 1;
    logic [1:0] REQ = 0, REQ_WR = 0, REQ_DIR = 0;
    logic [15:0] REQ_WDATA0 = 0, REQ_WDATA1 = 0;
    logic [31:0] HRDATA = 0;
    logic [1:0] ACK, PENDING, HTRANS;
    logic ERR, HSEL, HWRITE, HREADY;
    logic [15:0] RDATA;
    logic [31:0] HADDR, HWDATA;

    gpio_bus_arbiter #(.BASE_ADDR(BASE), .DATA_W(16), .TIMEOUT_CYC(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_DIR(REQ_DIR),
        .REQ_WDATA0(REQ_WDATA0), .REQ_WDATA1(REQ_WDATA1), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
        .PENDING(PENDING), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT));

    always #5 HCLK = ~HCLK;

    typedef struct {
        int g; int r; int a0; int d0;
        logic err; logic has_d; logic wr;
        logic [15:0] rdata; logic [31:0] addr; logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0, cyc = 0;
    int free_at = 0, a0 = 1, a1 = 0, d0 = 1, d1 = 0, aw = 0, dw = 0, r_cur = -1, g_cur = 0;
    int force_aw = -1, force_dw = -1;
    bit rnd_waits = 0, run = 0;
    logic [1:0] m_pend = 0, m_next = 0, s_wr = 0, s_dir = 0;
    logic [15:0] s_wd[2];
    logic m_ptr = 1;
    logic [15:0] m_rdata = 0;
    logic [31:0] hr_cur = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
        end
    endtask

    task automatic check_zero(input string n);
        chk({n, "_ack"}, 32'(ACK), 0);
        chk({n, "_err"}, 32'(ERR), 0);
        chk({n, "_rdata"}, 32'(RDATA), 0);
        chk({n, "_pending"}, 32'(PENDING), 0);
        chk({n, "_hsel"}, 32'(HSEL), 0);
        chk({n, "_haddr"}, HADDR, 0);
        chk({n, "_htrans"}, 32'(HTRANS), 0);
        chk({n, "_hwrite"}, 32'(HWRITE), 0);
        chk({n, "_hwdata"}, HWDATA, 0);
    endtask

    function automatic int pick_wait();
        int x = int'($urandom_range(0, 19));
        if (!rnd_waits) return 0;
        return x < 12 ? 0 : x < 17 ? int'($urandom_range(1, 3)) : int'($urandom_range(16, 18));
    endfunction

    // One clock of stimulus; the model decides service order and timing from the rules, not from the DUT.
    task automatic step(input logic [1:0] req, input logic [1:0] wr, input logic [1:0] dir,
                        input logic [15:0] w0, input logic [15:0] w1);
        exp_t e;
        int A, D, g;
        logic [1:0] acc, clr;
        @(posedge HCLK); #1;
        m_pend = m_next;
        cyc++;
        REQ = req; REQ_WR = wr; REQ_DIR = dir; REQ_WDATA0 = w0; REQ_WDATA1 = w1;
        if (cyc >= free_at && m_pend != 0) begin
            g = (m_pend == 2'b11) ? int'(!m_ptr) : int'(m_pend[1]);
            m_ptr = g[0];
            aw = force_aw >= 0 ? force_aw : pick_wait();
            dw = force_dw >= 0 ? force_dw : pick_wait();
            force_aw = -1; force_dw = -1;
            hr_cur = $urandom;
            A = aw >= TO ? TO : aw + 1;
            a0 = cyc + 1; a1 = cyc + A;
            e.g = g; e.a0 = a0; e.d0 = 0; e.wr = s_wr[g];
            e.addr = BASE + (s_dir[g] ? 32'd4 : 32'd0);
            e.wdata = {16'h0, s_wd[g]};
            if (aw >= TO) begin
                e.has_d = 0; e.err = 1; d0 = 1; d1 = 0; r_cur = a1 + 1;
            end else begin
                D = dw >= TO ? TO : dw + 1;
                d0 = a1 + 1; d1 = a1 + D; r_cur = d1 + 1;
                e.has_d = 1; e.d0 = d0; e.err = dw >= TO;
                if (!s_wr[g] && dw < TO) m_rdata = hr_cur[15:0];
            end
            e.rdata = m_rdata; e.r = r_cur; g_cur = g; free_at = r_cur + 1;
            sb.push_back(e);
        end
        HREADYOUT = (cyc >= a0 && cyc <= a1) ? (cyc >= a0 + aw) :
                    (cyc >= d0 && cyc <= d1) ? (cyc >= d0 + dw) : 1'($urandom);
        HRDATA = (cyc >= d0 && cyc <= d1) ? hr_cur : $urandom;
        clr = (cyc == r_cur) ? (2'b01 << g_cur) : 2'b00;
        acc = req & (~m_pend | clr);
        for (int i = 0; i < 2; i++) if (acc[i]) begin
            s_wr[i] = wr[i]; s_dir[i] = dir[i]; s_wd[i] = i ? w1 : w0;
        end
        m_next = acc | (m_pend & ~clr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    endtask

    always @(negedge HCLK) if (run && HRESETn) begin
        exp_t e;
        logic sel;
        sel = cyc >= a0 && cyc <= a1;
        chk("hsel", 32'(HSEL), 32'(sel));
        chk("htrans", 32'(HTRANS), sel ? 32'd2 : 32'd0);
        chk("pending", 32'(PENDING), 32'(m_pend));
        if (sb.size() > 0) begin
            if (cyc == sb[0].a0) begin
                chk("haddr", HADDR, sb[0].addr);
                chk("hwrite", 32'(HWRITE), 32'(sb[0].wr));
            end
            if (sb[0].has_d && cyc == sb[0].d0) chk("hwdata", HWDATA, sb[0].wdata);
        end
        if (ACK != 0 || (sb.size() > 0 && sb[0].r <= cyc)) begin
            if (sb.size() == 0) chk("spurious_ack", 32'(ACK), 0);
            else begin
                e = sb.pop_front();
                chk("ack", 32'(ACK), 32'(2'b01 << e.g));
                chk("ack_cycle", cyc, e.r);
                chk("err", 32'(ERR), 32'(e.err));
                chk("rdata", 32'(RDATA), 32'(e.rdata));
            end
        end
    end

    initial begin
        s_wd[0] = 0; s_wd[1] = 0;
        repeat (3) @(posedge HCLK);
        check_zero("reset");
        #1 HRESETn = 1; run = 1;
        // dir then data write, zero wait states
        step(2'b01, 2'b01, 2'b01, 16'h0001, 16'h0); idle(6);
        step(2'b01, 2'b01, 2'b00, 16'hA5A5, 16'h0); idle(6);
        // simultaneous reads
        step(2'b11, 2'b00, 2'b00, 16'h1234, 16'h5678); idle(12);
        // three data-phase wait states
        force_dw = 3; step(2'b01, 2'b00, 2'b00, 16'h0, 16'h0); idle(10);
        // address-phase timeout with the other requester waiting
        force_aw = 16; step(2'b11, 2'b10, 2'b01, 16'h0BEE, 16'hCAFE); idle(35);
        // second REQ while pending must be dropped
        step(2'b01, 2'b01, 2'b00, 16'h1111, 16'h0);
        step(2'b01, 2'b01, 2'b00, 16'h2222, 16'h0); idle(8);
        // reset in the middle of a data phase
        force_dw = 6; step(2'b01, 2'b00, 2'b00, 16'h0, 16'h0);
        for (int k = 0; k < 20 && !(cyc > d0 && cyc <= d1); k++) idle(1);
        chk("reach_data_phase", 32'(cyc > d0 && cyc <= d1), 1);
        HRESETn = 0; REQ = 0;
        #1 check_zero("midreset");
        sb.delete();
        m_pend = 0; m_next = 0; m_ptr = 1; m_rdata = 0; free_at = 0;
        a0 = 1; a1 = 0; d0 = 1; d1 = 0; r_cur = -1;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1;
        idle(10);
        // random traffic with occasional long stalls
        rnd_waits = 1;
        for (int n = 0; n < 1500; n++)
            step({$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3}, 2'($urandom), 2'($urandom),
                 16'($urandom), 16'($urandom));
        idle(60);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
